// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared defaults and helpers for the parametrised synchronous FIFO.
//   DEF_DATA_W : default data word width
//   DEF_DEPTH  : default number of entries
//   ptr_w()    : pointer width for a given depth
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// ---------------------------------------------------------------------------
// fifo_sync_param_if
// Producer/consumer bus of fifo_sync_param.
//   master : drives wr_en, wr_data, rd_en, clr_err; observes read data/status
//   slave  : the FIFO side (opposite directions)
// Handshake: a write is taken on a rising clk edge when wr_en=1 and full=0;
// a read is taken when rd_en=1 and empty=0. There is no back-pressure other
// than full/empty; refused requests only set the sticky error flags.
// ---------------------------------------------------------------------------
interface fifo_sync_param_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);
    localparam int CW = ptr_w(DEPTH) + 1;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic              clr_err;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
// Simple dual-port register array: one synchronous write port, one
// asynchronous read port. Contents are never reset.
//   i_clk   : clock, rising edge
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational from i_raddr)
// ---------------------------------------------------------------------------
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                       i_clk,
    input  logic                       i_we,
    input  logic [ptr_w(DEPTH)-1:0]    i_waddr,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic [ptr_w(DEPTH)-1:0]    i_raddr,
    output logic [DATA_W-1:0]          o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // DEPTH is a power of two, so every address value is a valid entry.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// ---------------------------------------------------------------------------
// fifo_sync_param
// Parametrised single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
//   clk : clock, rising edge
//   rst : synchronous, active-high reset
//   bus : fifo_sync_param_if.slave (write/read requests, data, status)
// Build option FIFO_FWFT_EN: when defined, rd_data shows the head word
// combinationally and rd_valid = !empty (first-word-fall-through); when
// undefined, rd_data is registered one cycle after an accepted read and
// rd_valid pulses for that cycle.
// ---------------------------------------------------------------------------
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_sync_param_if.slave     bus
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    // Static configuration checks, evaluated at elaboration.
    if (DATA_W < 1) begin : g_bad_width
        $error("fifo_sync_param: DATA_W must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_sync_param: DEPTH must be a power of two >= 2");
    end
    if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_af
        $error("fifo_sync_param: AF_THRESH outside 0..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_bad_ae
        $error("fifo_sync_param: AE_THRESH outside 0..DEPTH");
    end

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [DATA_W-1:0] w_mem_rdata;

    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);

    // Acceptance looks only at registered full/empty, never at the opposite
    // request, so a full FIFO refuses a write even when a read is taken.
    assign w_wr_acc = bus.wr_en && !w_full;
    assign w_rd_acc = bus.rd_en && !w_empty;

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_wr_acc && !rst),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_rdata)
    );

    // Pointers and occupancy; pointers roll over naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as clr_err wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wr_en && w_full) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_overflow <= 1'b0;
            end
            if (bus.rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end else if (bus.clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is always on display; rd_en pops it.
    assign bus.rd_data  = w_mem_rdata;
    assign bus.rd_valid = !w_empty;
`else
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;

    // rd_data holds its last value between accepted reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_data <= w_mem_rdata;
            end
        end
    end

    assign bus.rd_data  = r_rd_data;
    assign bus.rd_valid = r_rd_valid;
`endif

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= AF_C);
    assign bus.almost_empty = (r_count <= AE_C);
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_sync_param_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

  fifo_sync_param #(
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .AF_THRESH (14),
    .AE_THRESH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus cycle. Returns the word popped by this cycle's rd_en and whether
  // a pop happened, sampled where each read mode presents it.
  task automatic xfer(input logic we, input logic [DW-1:0] wd, input logic re,
                      output logic [DW-1:0] rdat, output logic rv);
    bus.wr_en   = we;
    bus.wr_data = wd;
    bus.rd_en   = re;
`ifdef FIFO_FWFT_EN
    #1;
    rdat = bus.rd_data;
    rv   = bus.rd_valid && re;
    tick();
`else
    tick();
    rdat = bus.rd_data;
    rv   = bus.rd_valid;
`endif
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.rd_en = 1'b0; bus.clr_err = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", bus.empty); end
    checks++; if (bus.almost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty: got %0b expected 1", bus.almost_empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", bus.full); end
    checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull: got %0b expected 0", bus.almost_full); end
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %0b expected 0", bus.rd_valid); end
    checks++; if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++; $display("FAIL reset_err_flags: got ovf=%0b unf=%0b expected 0 0", bus.overflow, bus.underflow);
    end
`ifndef FIFO_FWFT_EN
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %0h expected 0", bus.rd_data); end
`endif
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] rdat;
    logic rv;
    int vcount;
    for (int i = 1; i <= 16; i++) begin
      xfer(1'b1, DW'(i), 1'b0, rdat, rv);
      checks++; if (bus.count !== 5'(i)) begin errors++; $display("FAIL fill_count: got %0d expected %0d", bus.count, i); end
      checks++; if (bus.almost_full !== (i >= 14)) begin errors++; $display("FAIL fill_afull at %0d: got %0b expected %0b", i, bus.almost_full, (i >= 14)); end
      checks++; if (bus.almost_empty !== (i <= 2)) begin errors++; $display("FAIL fill_aempty at %0d: got %0b expected %0b", i, bus.almost_empty, (i <= 2)); end
      checks++; if (bus.full !== (i == 16)) begin errors++; $display("FAIL fill_full at %0d: got %0b expected %0b", i, bus.full, (i == 16)); end
    end
    vcount = 0;
    for (int i = 1; i <= 16; i++) begin
      xfer(1'b0, '0, 1'b1, rdat, rv);
      if (rv === 1'b1) vcount++;
      checks++; if (rdat !== DW'(i)) begin errors++; $display("FAIL drain_data: got %0h expected %0h", rdat, i); end
    end
    for (int i = 0; i < 2; i++) begin
      xfer(1'b0, '0, 1'b0, rdat, rv);
      if (rv === 1'b1) vcount++;
    end
    checks++; if (vcount != 16) begin errors++; $display("FAIL drain_valid_cycles: got %0d expected 16", vcount); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %0b expected 1", bus.empty); end
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL drain_underflow: got %0b expected 0", bus.underflow); end
  endtask

  task automatic test_full_rw();
    logic [DW-1:0] rdat;
    logic rv;
    for (int i = 0; i < 16; i++) xfer(1'b1, 8'h20 + DW'(i), 1'b0, rdat, rv);
    xfer(1'b1, 8'hAA, 1'b1, rdat, rv);
    checks++; if (rdat !== 8'h20 || rv !== 1'b1) begin errors++; $display("FAIL full_rw_read: got %0h/%0b expected 20/1", rdat, rv); end
    checks++; if (bus.count !== 5'd15) begin errors++; $display("FAIL full_rw_count: got %0d expected 15", bus.count); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL full_rw_overflow: got %0b expected 1", bus.overflow); end
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow: got %0b expected 0", bus.overflow); end
    for (int i = 1; i < 16; i++) begin
      xfer(1'b0, '0, 1'b1, rdat, rv);
      checks++; if (rdat !== 8'h20 + DW'(i)) begin errors++; $display("FAIL full_rw_drain: got %0h expected %0h", rdat, 8'h20 + i); end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL full_rw_empty: got %0b expected 1", bus.empty); end
  endtask

  task automatic test_empty_rw();
    logic [DW-1:0] rdat;
    logic rv;
    xfer(1'b1, 8'h55, 1'b1, rdat, rv);
    checks++; if (rv !== 1'b0) begin errors++; $display("FAIL empty_rw_refused: got valid %0b expected 0", rv); end
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL empty_rw_count: got %0d expected 1", bus.count); end
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL empty_rw_underflow: got %0b expected 1", bus.underflow); end
    xfer(1'b0, '0, 1'b1, rdat, rv);
    checks++; if (rdat !== 8'h55 || rv !== 1'b1) begin errors++; $display("FAIL empty_rw_read: got %0h/%0b expected 55/1", rdat, rv); end
    // set and clear in the same cycle: set must win
    bus.clr_err = 1'b1;
    xfer(1'b0, '0, 1'b1, rdat, rv);
    bus.clr_err = 1'b0;
    checks++; if (bus.underflow !== 1'b1) begin errors++; $display("FAIL set_beats_clr: got %0b expected 1", bus.underflow); end
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL clr_underflow: got %0b expected 0", bus.underflow); end
  endtask

  task automatic test_latency();
    logic [DW-1:0] rdat;
    logic rv;
    xfer(1'b1, 8'h3C, 1'b0, rdat, rv);
`ifdef FIFO_FWFT_EN
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h3C) begin
      errors++; $display("FAIL fwft_visible: got %0h/%0b expected 3c/1", bus.rd_data, bus.rd_valid);
    end
    xfer(1'b0, '0, 1'b1, rdat, rv);
    checks++; if (bus.empty !== 1'b1 || bus.rd_valid !== 1'b0) begin
      errors++; $display("FAIL fwft_pop: got empty=%0b valid=%0b expected 1 0", bus.empty, bus.rd_valid);
    end
`else
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL lat_no_early_valid: got %0b expected 0", bus.rd_valid); end
    bus.rd_en = 1'b1;
    #1;
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL lat_not_comb: got %0b expected 0", bus.rd_valid); end
    tick();
    bus.rd_en = 1'b0;
    checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h3C) begin
      errors++; $display("FAIL lat_one_cycle: got %0h/%0b expected 3c/1", bus.rd_data, bus.rd_valid);
    end
    tick();
    checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 8'h3C) begin
      errors++; $display("FAIL lat_hold: got %0h/%0b expected 3c/0", bus.rd_data, bus.rd_valid);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rdat;
    logic [DW-1:0] exp;
    logic [DW-1:0] wd;
    logic rv;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      wd = 8'h80 + DW'(i);
      xfer(1'b1, wd, 1'b0, rdat, rv);
      exp_q.push_back(wd);
    end
    for (int i = 0; i < 40; i++) begin
      wd = 8'hC0 + DW'(i);
      xfer(1'b1, wd, 1'b1, rdat, rv);
      exp = exp_q.pop_front();
      exp_q.push_back(wd);
      checks++; if (rdat !== exp || rv !== 1'b1) begin errors++; $display("FAIL b2b_data %0d: got %0h/%0b expected %0h/1", i, rdat, rv, exp); end
    end
    checks++; if (bus.count !== 5'd8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", bus.count); end
    for (int i = 0; i < 8; i++) begin
      xfer(1'b0, '0, 1'b1, rdat, rv);
      exp = exp_q.pop_front();
      checks++; if (rdat !== exp) begin errors++; $display("FAIL b2b_drain: got %0h expected %0h", rdat, exp); end
    end
    checks++; if (bus.empty !== 1'b1 || bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
      errors++; $display("FAIL b2b_end: got empty=%0b ovf=%0b unf=%0b expected 1 0 0", bus.empty, bus.overflow, bus.underflow);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rdat;
    logic rv;
    for (int i = 0; i < 5; i++) xfer(1'b1, 8'h60 + DW'(i), 1'b0, rdat, rv);
    checks++; if (bus.count !== 5'd5) begin errors++; $display("FAIL rmid_pre_count: got %0d expected 5", bus.count); end
    rst = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h77; bus.rd_en = 1'b1;
    tick();
    rst = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    checks++; if (bus.count !== 5'd0 || bus.empty !== 1'b1) begin
      errors++; $display("FAIL rmid_count: got %0d empty=%0b expected 0 1", bus.count, bus.empty);
    end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL rmid_rd_valid: got %0b expected 0", bus.rd_valid); end
`ifndef FIFO_FWFT_EN
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL rmid_rd_data: got %0h expected 0", bus.rd_data); end
`endif
    xfer(1'b0, '0, 1'b1, rdat, rv);
    checks++; if (bus.underflow !== 1'b1 || rv !== 1'b0) begin
      errors++; $display("FAIL rmid_underflow: got unf=%0b valid=%0b expected 1 0", bus.underflow, rv);
    end
    xfer(1'b1, 8'h11, 1'b0, rdat, rv);
    checks++; if (bus.count !== 5'd1) begin errors++; $display("FAIL rmid_rewrite_count: got %0d expected 1", bus.count); end
    xfer(1'b0, '0, 1'b1, rdat, rv);
    checks++; if (rdat !== 8'h11) begin errors++; $display("FAIL rmid_rewrite_data: got %0h expected 11", rdat); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_empty_rw();
    test_latency();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
